// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
//   Shared constants, types and helpers for the 8x8 bicolour LED row-scan
//   driver. It holds the matrix geometry, the colour-enable bit indices, the
//   scan state encoding, the reset row pattern, the buffered-frame record and
//   a row-byte extractor.
package led_matrix_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int COL_GREEN = 0;
  localparam int COL_RED   = 1;

  // Row index 0 is the MSB of the row bus.
  localparam logic [ROWS-1:0] ROW_RESET = 8'b1000_0000;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  // One buffered frame: the 64 pixel bits plus the colour enables that were
  // captured with it.
  typedef struct packed {
    logic [ROWS*COLS-1:0] frame;
    logic [1:0]           color;
  } frame_t;

  // Row r is frame bits [63-8r : 56-8r], so row 0 is the top byte.
  function automatic logic [COLS-1:0] row_byte(input logic [ROWS*COLS-1:0] frame,
                                               input logic [2:0]           idx);
    int lsb;
    lsb = (ROWS - 1 - int'(idx)) * COLS;
    return frame[lsb +: COLS];
  endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// scan_timer
//   Dwell/blank cycle counter for the row-scan driver. It counts
//   0..SCAN_DIV-1 while the mode is SHOW and 0..BLANK_CYC-1 while the mode is
//   BLANK, then restarts from 0. The mode only changes on a terminal count, so
//   every interval starts from a cleared counter.
//   Ports:
//     clk    in  - system clock
//     reset  in  - asynchronous, active-low reset
//     i_mode in  - current scan state, which selects the terminal count
//     o_tc   out - high during the final cycle of the current interval
import led_matrix_pkg::*;

module scan_timer #(
  parameter int SCAN_DIV  = 8192,
  parameter int BLANK_CYC = 64,
  parameter int CNT_W     = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  scan_state_e i_mode,
  output logic        o_tc
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = (i_mode == BLANK) ? BLANK_LAST : SHOW_LAST;
  assign o_tc   = (r_cnt == w_last);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Row-scan driver for the 8x8 bicolour LED matrix. A complete frame and its
//   colour enables are captured into a pending buffer. At each frame boundary
//   (row index wrapping from 7 to 0), a valid pending frame is promoted to the
//   active buffer. Because the active buffer only changes at a boundary, a new
//   frame never tears mid-scan.
//   Optional feature macro: LED_SCAN_BLANK_EN. When it is defined, a dark
//   BLANK_CYC-cycle gap follows every row dwell to suppress ghosting.
//   Ports:
//     clk          in  - system clock
//     reset        in  - asynchronous, active-low reset
//     frame_in     in  - 64-bit frame, row-major, row 0 in the top byte
//     color        in  - bit 0 green enable, bit 1 red enable
//     frame_load   in  - strobe that captures frame_in/color into pending
//     load_ready   out - high while the pending buffer is empty
//     frame_done   out - high in the first cycle that row 0 is driven
//     row          out - one-hot row select; row 0 = 8'b1000_0000
//     column_green out - active row byte when green is enabled, else 0
//     column_red   out - active row byte when red is enabled, else 0
import led_matrix_pkg::*;

module led_matrix_scan #(
  parameter int SCAN_DIV  = 8192,
  parameter int BLANK_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic [1:0]           color,
  input  logic                 frame_load,
  output logic                 load_ready,
  output logic                 frame_done,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      column_green,
  output logic [COLS-1:0]      column_red
);

  localparam int CNT_W = $clog2((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC);
  localparam int IDX_W = $clog2(ROWS);

  frame_t           r_active, r_pending;
  logic             r_pend_valid;
  logic [IDX_W-1:0] r_idx;

  scan_state_e      w_state, w_state_nxt;
  logic             w_tc;
  logic             w_advance;
  logic             w_boundary;
  logic [IDX_W-1:0] w_idx_nxt;
  frame_t           w_active_nxt;
  logic             w_pend_valid_nxt;
  logic [COLS-1:0]  w_byte;
  logic             w_show_nxt;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_mode (w_state),
    .o_tc   (w_tc)
  );

`ifdef LED_SCAN_BLANK_EN
  scan_state_e r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SHOW;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      SHOW:  if (w_tc) w_state_nxt = BLANK;
      BLANK: if (w_tc) begin
               w_state_nxt = SHOW;
               w_advance   = 1'b1;
             end
    endcase
  end

  assign w_state = r_state;
`else
  // Without blanking, rows switch back-to-back on every dwell terminal count.
  assign w_state     = SHOW;
  assign w_state_nxt = SHOW;
  assign w_advance   = w_tc;
`endif

  // Outputs are registered from next-state values. This keeps row and the
  // column buses aligned with the state they describe on the same edge.
  always_comb begin
    w_idx_nxt        = w_advance ? r_idx + IDX_W'(1) : r_idx;
    w_boundary       = w_advance && (r_idx == IDX_W'(ROWS - 1));
    // The swap reads the old pending contents, even when a load lands on the
    // same edge. That load then waits in pending for the next boundary.
    w_active_nxt     = (w_boundary && r_pend_valid) ? r_pending : r_active;
    w_pend_valid_nxt = frame_load ? 1'b1 : (w_boundary ? 1'b0 : r_pend_valid);
    w_byte           = row_byte(w_active_nxt.frame, w_idx_nxt);
    w_show_nxt       = (w_state_nxt == SHOW);
  end

  // NOTE: both frame buffers are reset explicitly. A reset must discard any
  // frame in flight, and a cleared active buffer keeps the columns dark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      row          <= ROW_RESET;
      column_green <= '0;
      column_red   <= '0;
      load_ready   <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      r_active     <= w_active_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_idx        <= w_idx_nxt;
      if (frame_load) r_pending <= '{frame: frame_in, color: color};
      row          <= w_show_nxt ? (ROW_RESET >> w_idx_nxt) : '0;
      column_green <= (w_show_nxt && w_active_nxt.color[COL_GREEN]) ? w_byte : '0;
      column_red   <= (w_show_nxt && w_active_nxt.color[COL_RED])   ? w_byte : '0;
      load_ready   <= ~w_pend_valid_nxt;
      frame_done   <= w_boundary;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan
//   Self-checking bench for led_matrix_scan with SCAN_DIV = 4 and
//   BLANK_CYC = 2. The reference model tracks elapsed cycles since reset
//   release, which gives the frame position directly. It keeps the two
//   buffers as plain variables and derives every expected output from them.
//   It follows LED_SCAN_BLANK_EN, so the same bench covers both builds.
module tb_led_matrix_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
`ifdef LED_SCAN_BLANK_EN
  localparam int ROW_PER = SCAN_DIV + BLANK_CYC;
`else
  localparam int ROW_PER = SCAN_DIV;
`endif
  localparam int FRAME = 8 * ROW_PER;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] frame_in = '0;
  logic [1:0]  color = '0;
  logic        frame_load = 1'b0;
  logic        load_ready, frame_done;
  logic [7:0]  row, column_green, column_red;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_t;
  logic [63:0] m_act_f, m_pen_f;
  logic [1:0]  m_act_c, m_pen_c;
  logic        m_valid;

  always #5 clk = ~clk;

  led_matrix_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_in     (frame_in),
    .color        (color),
    .frame_load   (frame_load),
    .load_ready   (load_ready),
    .frame_done   (frame_done),
    .row          (row),
    .column_green (column_green),
    .column_red   (column_red)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t     = 0;
    m_act_f = '0;
    m_act_c = '0;
    m_pen_f = '0;
    m_pen_c = '0;
    m_valid = 1'b0;
  endtask

  // One clock edge. A frame boundary is every FRAME cycles after release.
  // The swap uses pending as it was before this edge's load.
  task automatic model_edge(input logic ld, input logic [63:0] f, input logic [1:0] c);
    if (!reset) begin
      model_reset();
    end else begin
      m_t++;
      if ((m_t % FRAME) == 0 && m_valid) begin
        m_act_f = m_pen_f;
        m_act_c = m_pen_c;
        m_valid = 1'b0;
      end
      if (ld) begin
        m_pen_f = f;
        m_pen_c = c;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int         p, slot;
    logic       lit;
    logic [7:0] b;
    p    = m_t % FRAME;
    slot = p / ROW_PER;
    lit  = (p % ROW_PER) < SCAN_DIV;
    b    = m_act_f[8*(7-slot) +: 8];
    check("row",          row,          lit ? (8'h80 >> slot) : 8'h00);
    check("column_green", column_green, (lit && m_act_c[0]) ? b : 8'h00);
    check("column_red",   column_red,   (lit && m_act_c[1]) ? b : 8'h00);
    check("frame_done",   frame_done,   (m_t > 0) && (p == 0));
    check("load_ready",   load_ready,   !m_valid);
  endtask

  task automatic tick(input logic ld, input logic [63:0] f, input logic [1:0] c);
    frame_load = ld;
    frame_in   = f;
    color      = c;
    @(posedge clk);
    model_edge(ld, f, c);
    #1;
    frame_load = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 64'h0, 2'b00);
  endtask

  task automatic wait_boundary();
    int k;
    k = 0;
    while (!frame_done && k < FRAME + 2) begin
      idle(1);
      k++;
    end
    check("wait_frame_done", frame_done, 1'b1);
  endtask

  localparam logic [63:0] F_LOAD = 64'hE000_0000_0000_0007;
  localparam logic [63:0] F_A    = 64'h0102_0408_1020_4080;
  localparam logic [63:0] F_B    = 64'hFF00_FF00_AA55_AA55;
  localparam logic [63:0] F_C    = 64'h8142_2418_1824_4281;
  localparam logic [63:0] F_D    = 64'hDEAD_BEEF_0123_4567;

  initial begin
    logic [63:0] fb, fc;
    model_reset();
    fb = F_B;
    fc = F_C;

    // Reset values while held in reset
    idle(3);
    check("rst_row", row, 8'h80);
    reset = 1'b1;

    // Free-running scan with an empty frame
    idle(ROW_PER);
    check("first_shift", row, 8'h40);
    idle(2 * FRAME);

    // Load and display
    tick(1'b1, F_LOAD, 2'b01);
    check("ready_fall", load_ready, 1'b0);
    wait_boundary();
    check("load_row0",  row, 8'h80);
    check("load_g0",    column_green, 8'hE0);
    check("ready_rise", load_ready, 1'b1);
    idle(7 * ROW_PER);
    check("load_row7", row, 8'h01);
    check("load_g7",   column_green, 8'h07);
    check("load_r7",   column_red, 8'h00);

    // Overwrite: A then B in one frame; only B may appear
    idle(ROW_PER);
    tick(1'b1, F_A, 2'b11);
    idle(3);
    tick(1'b1, F_B, 2'b10);
    wait_boundary();
    check("ovr_red0",   column_red, fb[63:56]);
    check("ovr_green0", column_green, 8'h00);

    // Load on the boundary edge with pending empty
    idle(FRAME - 1);
    tick(1'b1, F_C, 2'b01);
    check("lob_fd",    frame_done, 1'b1);
    check("lob_old",   column_red, fb[63:56]);
    check("lob_ready", load_ready, 1'b0);
    idle(FRAME - 1);
    check("lob_ready_hold", load_ready, 1'b0);
    idle(1);
    check("lob_new_fd", frame_done, 1'b1);
    check("lob_new_g",  column_green, fc[63:56]);
    check("lob_ready_rise", load_ready, 1'b1);

    // Random loads and colours against the model
    repeat (800) begin
      tick($urandom_range(0, 15) == 0, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    end

    // Reset mid-frame during row 3, with a frame pending
    while ((m_t % FRAME) != 3 * ROW_PER) idle(1);
    tick(1'b1, F_D, 2'b11);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("midrst_row", row, 8'h80);
    idle(3);
    reset = 1'b1;
    idle(ROW_PER);
    check("midrst_shift", row, 8'h40);
    wait_boundary();
    check("midrst_clear_g", column_green, 8'h00);
    check("midrst_clear_r", column_red, 8'h00);
    idle(FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-scan driver for the 8×8 bicolour LED matrix. It sits downstream of the pattern/marquee generators and consumes a complete 64-bit frame plus a colour select. The frame is double-buffered so an update never tears mid-scan. It drives the one-hot `row` bus and the `column_green`/`column_red` buses directly to the pins.

## Interface
- `SCAN_DIV`, default 8192 — clock cycles each row is lit (dwell); legal range ≥ 2.
- `BLANK_CYC`, default 64 — dark cycles after each row dwell; used only when `LED_SCAN_BLANK_EN` is defined; ≥ 1.
- `clk`  in  1  — system clock; single clock domain.
- `reset`  in  1  — asynchronous, active-low reset.
- `frame_in`  in  64  — frame, row-major: row r = bits [63-8r : 56-8r]; byte bit 7 = leftmost column.
- `color`  in  2  — bit 0 = green enable, bit 1 = red enable; sampled together with `frame_in`.
- `frame_load`  in  1  — one-cycle strobe that captures `frame_in`/`color` into the pending buffer.
- `load_ready`  out  1  — high when the pending buffer is empty.
- `frame_done`  out  1  — one-cycle pulse at each frame boundary.
- `row`  out  8  — active-high one-hot row select; row index 0 = 8'b1000_0000, index 7 = 8'b0000_0001.
- `column_green`  out  8  — active row byte when green is enabled, else 0.
- `column_red`  out  8  — active row byte when red is enabled, else 0.

## Operation
- Two 66-bit buffers, each holding frame plus colour:
  - pending, with a valid flag;
  - active, which drives the outputs.
- `frame_load` writes pending and sets the valid flag.
  - A load while the valid flag is already set overwrites pending (latest wins). No back-pressure is applied; `load_ready` is advisory.
- Frame boundary = the edge on which the row index wraps from 7 to 0. On that edge:
  - if pending is valid: active ← pending, valid flag ← 0;
  - `frame_done` ← 1 for that one cycle.
- Load on the boundary edge:
  - The swap uses the old pending contents.
  - The new data lands in pending with the valid flag set, and is swapped at the next boundary.
  - If pending was empty, no swap occurs that frame.
- FSM states:
  - SHOW: `row` = one-hot(idx); columns = active byte[idx] gated by the colour bits.
    - The dwell counter counts 0..SCAN_DIV-1.
    - At terminal count without blanking: idx ← idx+1 (mod 8), stay in SHOW.
    - At terminal count with blanking: go to BLANK.
  - BLANK (only with `LED_SCAN_BLANK_EN`): `row` = 0 and columns = 0 for BLANK_CYC cycles, then idx ← idx+1 and return to SHOW.
- `color` = 2'b00: rows still scan; both column buses stay 0.
- `color` = 2'b11: both buses carry the same byte (amber).
- Counter width is `$clog2(max(SCAN_DIV, BLANK_CYC))`. The counter never exceeds its terminal count.

## Timing
- Reset (asynchronous assert; release synchronous to `clk`) sets:
  - `row` = 8'b1000_0000, `column_green` = 0, `column_red` = 0;
  - `load_ready` = 1, `frame_done` = 0;
  - active frame = 0, colour = 0, pending valid = 0;
  - idx = 0, counter = 0, state = SHOW.
- Reset mid-frame discards both buffers immediately. Scanning restarts at row 0 after release.
- All outputs are registered. `row` and the column buses change on the same edge and never disagree for a cycle.
- `load_ready` falls on the edge after `frame_load`. It rises on the boundary edge that empties pending.
- Display latency: the new frame's row 0 appears on the first boundary edge after the `frame_load` edge.
  - Worst case is 8·SCAN_DIV cycles, or 8·(SCAN_DIV+BLANK_CYC) with blanking.
- Frame period is 8·SCAN_DIV cycles, or 8·(SCAN_DIV+BLANK_CYC) with blanking.
- `frame_done` is high in exactly the first cycle that row 0 of a frame is driven.

## Configuration
- `LED_SCAN_BLANK_EN` defined:
  - the BLANK state is compiled in;
  - a BLANK_CYC dark gap follows every row, to suppress ghosting.
- `LED_SCAN_BLANK_EN` undefined:
  - the BLANK state and its logic are absent;
  - rows switch back-to-back and `BLANK_CYC` is ignored.

## Structure
- Shared package `led_matrix_pkg` holds:
  - `ROWS` = 8, `COLS` = 8;
  - colour bit indices `COL_GREEN` = 0 and `COL_RED` = 1;
  - the scan state enum {SHOW, BLANK};
  - the reset row constant 8'b1000_0000.
- One sub-module, `scan_timer`:
  - contains the dwell/blank counter;
  - inputs: `clk`, `reset`, and a mode select;
  - output: a terminal-count strobe.
- Buffering, FSM and output registers stay in `led_matrix_scan`.

## Test plan
Benches use SCAN_DIV = 4 and BLANK_CYC = 2.
- **Reset values:** hold `reset` = 0 → `row` = 8'h80, both column buses = 0, `load_ready` = 1. Release → `row` shifts to 8'h40 after 4 cycles and wraps 8'h01 → 8'h80 with `frame_done` pulsing once every 32 cycles.
- **Load and display:** load `frame_in` = 64'hE000_0000_0000_0007 with `color` = 2'b01 → at the next boundary, `column_green` = 8'hE0 on row 8'h80 and 8'h07 on row 8'h01; `column_red` = 0 throughout; `load_ready` goes 0, then returns to 1 on the boundary edge.
- **Overwrite:** two loads, A then B, within one frame → only B is displayed; A is never seen.
- **Load on boundary:** `frame_load` coincident with the wrap edge, pending empty → the old frame repeats for one more frame, then the new frame appears; `load_ready` stays 0 for 32 cycles.
- **Reset mid-frame:** assert `reset` during row 3 → outputs return to reset values at once, both buffers are cleared, and scanning restarts at 8'h80 after release.
- **Blanking:** with `LED_SCAN_BLANK_EN` → `row` = 0 and columns = 0 for 2 cycles after every 4-cycle dwell; frame period = 48 cycles.
